// File: rtl/console_pkg.sv
// Shared constants and types for the memory-mapped console transmitter:
// default register addresses, status word bit positions and serialiser states.
package console_pkg;

  localparam logic [31:0] DEF_ADDR_DATA = 32'h1000_0000;
  localparam logic [31:0] DEF_ADDR_STAT = 32'h1000_0004;

  localparam int STAT_BUSY      = 0;
  localparam int STAT_FULL      = 1;
  localparam int STAT_EMPTY     = 2;
  localparam int STAT_COUNT_LSB = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/console_fifo.sv
// Single-clock byte FIFO, show-ahead read (pop_dat_o valid whenever not empty).
// Push while full and pop while empty are ignored; count saturates at DEPTH.
module console_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           push_dat_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           pop_dat_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  assign full_o    = (count_q == CW'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign count_o   = count_q;
  assign do_push   = push_i && !full_o;
  assign do_pop    = pop_i && !empty_o;
  assign pop_dat_o = mem_q[rd_ptr_q];

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_dat_i;
  end

endmodule

// File: rtl/console_uart_tx.sv
// PicoRV32-bus console: byte writes to the data register are queued and sent 8N1 on tx.
// mem_ready is a registered 1-cycle pulse; a data write into a full FIFO stalls until a pop.
module console_uart_tx
  import console_pkg::*;
#(
  parameter int          CLK_DIV    = 868,
  parameter int          FIFO_DEPTH = 16,
  parameter logic [31:0] ADDR_DATA  = DEF_ADDR_DATA,
  parameter logic [31:0] ADDR_STAT  = DEF_ADDR_STAT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_valid,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic        tx
);

  localparam int          CW     = $clog2(FIFO_DEPTH) + 1;
  localparam logic [15:0] DIV_M1 = 16'(CLK_DIV - 1);

  logic          fifo_push;
  logic          fifo_pop;
  logic [7:0]    fifo_dat;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;

  logic          hit_data;
  logic          hit_stat;
  logic          is_write;
  logic          stall;
  logic          accept;
  logic [31:0]   stat_word;
  logic          unused_wdata;

  logic          mem_ready_q, mem_ready_d;
  logic [31:0]   mem_rdata_q, mem_rdata_d;

  tx_state_e     state_q, state_d;
  logic [15:0]   cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;

  console_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (reset),
    .push_i     (fifo_push),
    .push_dat_i (mem_wdata[7:0]),
    .pop_i      (fifo_pop),
    .pop_dat_o  (fifo_dat),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .count_o    (fifo_count)
  );

  assign unused_wdata = ^mem_wdata[31:8];

  // Bus decode. The ready pulse blocks acceptance for its own cycle so one request pushes once.
  assign hit_data  = (mem_addr == ADDR_DATA);
  assign hit_stat  = (mem_addr == ADDR_STAT);
  assign is_write  = |mem_wstrb;
  assign stall     = hit_data && mem_wstrb[0] && fifo_full;
  assign accept    = mem_valid && !mem_ready_q && (hit_data || hit_stat) && !stall;
  assign fifo_push = accept && hit_data && mem_wstrb[0];

  always_comb begin
    stat_word                           = '0;
    stat_word[STAT_BUSY]                = (state_q != IDLE);
    stat_word[STAT_FULL]                = fifo_full;
    stat_word[STAT_EMPTY]               = fifo_empty;
    stat_word[STAT_COUNT_LSB +: 8]      = 8'(fifo_count);
  end

  always_comb begin
    mem_ready_d = accept;
    mem_rdata_d = (accept && hit_stat && !is_write) ? stat_word : '0;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    fifo_pop = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_dat;
          state_d  = START;
          cnt_d    = DIV_M1;
        end
      end
      START: begin
        if (cnt_q == 16'd0) begin
          state_d = DATA;
          idx_d   = 3'd0;
          cnt_d   = DIV_M1;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      DATA: begin
        if (cnt_q == 16'd0) begin
          cnt_d = DIV_M1;
          if (idx_q == 3'd7) state_d = STOP;
          else               idx_d   = idx_q + 3'd1;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      STOP: begin
        if (cnt_q == 16'd0) begin
          state_d = IDLE;
          cnt_d   = DIV_M1;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    // tx is registered from next state so the pin is glitch-free and tracks the FSM cycle-exactly.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[idx_d];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_ready_q <= 1'b0;
      mem_rdata_q <= '0;
      state_q     <= IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      tx_q        <= 1'b1;
    end else begin
      mem_ready_q <= mem_ready_d;
      mem_rdata_q <= mem_rdata_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      tx_q        <= tx_d;
    end
  end

  assign mem_ready = mem_ready_q;
  assign mem_rdata = mem_rdata_q;
  assign tx        = tx_q;

endmodule

// File: doc/console_uart_tx.md
# console_uart_tx

Memory-mapped console transmitter on the PicoRV32 native memory bus. Acts as the bus responder for CPU byte writes to the console data address, buffers them in a small FIFO, and serialises each byte on an 8N1 UART line. This puts the console traffic that firmware writes to 0x1000_0000 on a physical pin. A status word lets firmware poll FIFO state before writing.

## Interface
- `CLK_DIV`, 868: clock cycles per UART bit (100 MHz / 115200); legal range 2..65535.
- `FIFO_DEPTH`, 16: byte entries; power of two, 2..256.
- `ADDR_DATA`, 32'h1000_0000: TX data register address.
- `ADDR_STAT`, 32'h1000_0004: status register address.

Ports:
- `clk`  in  1  single clock; all logic on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `mem_valid`  in  1  bus request valid (PicoRV32 native).
- `mem_addr`  in  32  request address.
- `mem_wdata`  in  32  write data; byte in [7:0].
- `mem_wstrb`  in  4  write strobes; all-zero means read.
- `mem_ready`  out  1  one-cycle completion pulse, only for decoded addresses.
- `mem_rdata`  out  32  read data, valid while `mem_ready`=1; 0 otherwise.
- `tx`  out  1  UART serial output, idle high.

## Operation
- Decode is exact 32-bit match on `ADDR_DATA` or `ADDR_STAT`. Other addresses get no response: `mem_ready` stays 0 and no state changes.
- Write `ADDR_DATA` with `mem_wstrb[0]`=1:
  - If FIFO not full, push `mem_wdata[7:0]` and pulse `mem_ready`.
  - If full, hold `mem_ready` low (CPU stalls) until space exists, then accept.
- Write `ADDR_DATA` with `mem_wstrb[0]`=0: completes with no push.
- Writes to `ADDR_STAT` complete with no effect.
- Read `ADDR_DATA` returns 0.
- Read `ADDR_STAT` returns:
  - [0] busy: serialiser not IDLE.
  - [1] full.
  - [2] empty.
  - [15:8] FIFO count.
  - Remaining bits 0.
- Serialiser FSM:
  - IDLE: `tx`=1. If FIFO is non-empty, pop into the shift register and go to START.
  - START: `tx`=0 for `CLK_DIV` cycles, then DATA.
  - DATA: 8 bits, LSB first, `CLK_DIV` cycles each; a 3-bit index counts 0..7, then STOP.
  - STOP: `tx`=1 for `CLK_DIV` cycles, then IDLE.
- Bit timer is a 16-bit down-counter. It loads `CLK_DIV-1` on each state entry, and the state advances when the counter is 0.
- Back-to-back bytes: a STOP→IDLE→START sequence adds exactly one idle cycle between frames.

## Timing
- Reset values: `mem_ready`=0, `mem_rdata`=0, `tx`=1, FIFO empty, FSM IDLE, counters 0.
- `mem_ready` is registered and asserted the cycle after `mem_valid` is sampled with an acceptable request, so minimum latency is 1 cycle.
- `mem_ready` deasserts after one cycle, even if `mem_valid` stays high.
- A request is never accepted in the cycle `mem_ready`=1, so one request gives one push.
- FIFO push takes effect on the edge where `mem_ready` rises.
  - With FIFO empty and FSM IDLE, the pop/START transition happens on the next edge.
  - `tx` first reads 0 in the cycle after that edge, 2 cycles after the handshake.
- Full FIFO with a pop in the same cycle: the push is not accepted that cycle; it is accepted on the next evaluation. Count never exceeds `FIFO_DEPTH`.
- Status reads reflect the state registered at the cycle `mem_valid` is sampled.
- Reset mid-frame: `tx` returns high asynchronously, the FIFO is flushed, and the partial byte is lost. An in-flight bus request is dropped with no `mem_ready`.

## Structure
- Package `console_pkg` holds:
  - default address constants;
  - status bit index constants (`STAT_BUSY`=0, `STAT_FULL`=1, `STAT_EMPTY`=2, `STAT_COUNT_LSB`=8);
  - FSM state type {IDLE, START, DATA, STOP}.
- Sub-module `console_fifo`: synchronous single-clock FIFO.
  - Parameters: width 8, `FIFO_DEPTH`.
  - Ports: push/pop/full/empty/count, plus asynchronous active-high reset.
- Bus decode, ready generation and serialiser live in the top module.

## Test plan
- Single write: after reset, write 0x41 to 0x1000_0000 → `mem_ready` 1 cycle later.
  - `tx` low 2 cycles after the handshake.
  - Bits 1,0,0,0,0,0,1,0 (LSB first), then stop high, each `CLK_DIV` cycles (use `CLK_DIV`=4).
- Status poll: with FIFO empty, read 0x1000_0004 → 0x0000_0004.
  - After three fast writes during a frame → busy=1, count=2 (0x0000_0201).
- Backpressure: `FIFO_DEPTH`=4, `CLK_DIV`=4. Issue 6 writes back-to-back.
  - The sixth `mem_ready` is withheld until the serialiser pops.
  - All 6 bytes appear on `tx` in order with one idle cycle between frames.
- Decode: write to 0x1000_0008 → no `mem_ready` for 20 cycles, count unchanged.
  - Read of 0x1000_0000 → `mem_rdata`=0 with `mem_ready`.
- Reset mid-frame: assert `reset` during bit 3 of a frame with 2 bytes queued.
  - `tx`=1 immediately.
  - After release, status reads 0x0000_0004 and `tx` stays high.
